// File: rtl/return_addr_stack.sv
// ---------------------------------------------------------------------------
// return_addr_stack
//   Return address stack for the fetch front end. Calls push their return
//   address, returns pop the predicted target. Entries live in a circular
//   buffer addressed by a top pointer, so pushes on a full stack silently
//   overwrite the oldest entry and raise a one-cycle overflow pulse.
//
// Ports
//   clk_i       in   1        clock; all state updates on its rising edge
//   rst_i       in   1        synchronous active-high reset (highest priority)
//   flush_i     in   1        discard all entries (redirect); beats push/pop
//   push_i      in   1        call detected: push addr_i
//   pop_i       in   1        return detected: pop the top entry
//   addr_i      in   VLEN     return address to push
//   ra_valid_o  out  1        top entry holds a valid prediction
//   ra_o        out  VLEN     predicted return address (top entry)
//   count_o     out  PTR_W+1  number of valid entries
//   overflow_o  out  1        pulse: last push discarded the oldest entry
// ---------------------------------------------------------------------------
module return_addr_stack #(
    parameter int DEPTH = 4,
    parameter int VLEN  = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [VLEN-1:0]            addr_i,
    output logic                       ra_valid_o,
    output logic [VLEN-1:0]            ra_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [VLEN-1:0]  entry [DEPTH];
    logic [PTR_W-1:0] tp;
    logic [CNT_W-1:0] count;
    logic             overflow_q;

    logic [PTR_W-1:0] tp_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             overflow_nxt;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic             empty;

    assign empty = (count == '0);

    // Next-state decode. Reset and flush both clear the control state and
    // suppress the entry write; everything else follows the push/pop pair.
    always_comb begin
        tp_nxt       = tp;
        count_nxt    = count;
        overflow_nxt = 1'b0;
        wr_en        = 1'b0;
        wr_idx       = tp;

        if (rst_i || flush_i) begin
            tp_nxt    = '0;
            count_nxt = '0;
        end else if (push_i && pop_i && !empty) begin
            // Co-routine jump: the return consumes the top, the call
            // replaces it in place, so depth does not change.
            wr_en  = 1'b1;
            wr_idx = tp;
        end else if (push_i) begin
            // Covers push+pop on an empty stack too: the pop has nothing
            // to consume. tp wraps naturally at PTR_W bits.
            tp_nxt = tp + 1'b1;
            wr_en  = 1'b1;
            wr_idx = tp + 1'b1;
            if (count == FULL) begin
                overflow_nxt = 1'b1;
            end else begin
                count_nxt = count + 1'b1;
            end
        end else if (pop_i && !empty) begin
            tp_nxt    = tp - 1'b1;
            count_nxt = count - 1'b1;
        end
    end

    // Control state: reset applies here only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tp         <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            tp         <= tp_nxt;
            count      <= count_nxt;
            overflow_q <= overflow_nxt;
        end
    end

    // Entry storage: data is never reset, validity is tracked by count.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            entry[wr_idx] <= addr_i;
        end
    end

    // Prediction is read straight from registered state so a return in
    // the same cycle consumes the value being presented.
    assign ra_o       = entry[tp];
    assign ra_valid_o = !empty;
    assign count_o    = count;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_return_addr_stack.sv
module tb_return_addr_stack;

    localparam int DEPTH = 4;
    localparam int VLEN  = 64;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              flush_i = 1'b0;
    logic              push_i = 1'b0;
    logic              pop_i = 1'b0;
    logic [VLEN-1:0]   addr_i = '0;
    logic              ra_valid_o;
    logic [VLEN-1:0]   ra_o;
    logic [$clog2(DEPTH):0] count_o;
    logic              overflow_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic        v;
        logic [63:0] ra;
        int          cnt;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];

    return_addr_stack #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .push_i     (push_i),
        .pop_i      (pop_i),
        .addr_i     (addr_i),
        .ra_valid_o (ra_valid_o),
        .ra_o       (ra_o),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input string field,
                       input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed 0x%0h expected 0x%0h", tag, field, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected post-edge state,
    // then sample #1 after the edge and compare against the queue head.
    task automatic step(input string tag, input logic r, input logic f,
                        input logic pu, input logic po, input logic [63:0] a,
                        input logic ev, input logic [63:0] era,
                        input int ecnt, input logic eovf);
        exp_t e;
        exp_t got;
        rst_i   = r;
        flush_i = f;
        push_i  = pu;
        pop_i   = po;
        addr_i  = a;
        e.tag = tag; e.v = ev; e.ra = era; e.cnt = ecnt; e.ovf = eovf;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0; flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0;
        got = exp_q.pop_front();
        chk(got.tag, "valid", 64'(ra_valid_o), 64'(got.v));
        chk(got.tag, "count", 64'(count_o), 64'(got.cnt));
        chk(got.tag, "ovf", 64'(overflow_o), 64'(got.ovf));
        if (got.v) chk(got.tag, "ra", ra_o, got.ra);
    endtask

    initial begin
        // Reset, with a push asserted that must be discarded
        step("rst_push", 1, 0, 1, 0, 64'h55, 0, 0, 0, 0);
        step("rst2",     1, 0, 0, 0, 0,      0, 0, 0, 0);
        step("idle_rst", 0, 0, 0, 0, 0,      0, 0, 0, 0);

        // Basic LIFO
        step("p1000", 0, 0, 1, 0, 64'h1000, 1, 64'h1000, 1, 0);
        step("p2000", 0, 0, 1, 0, 64'h2000, 1, 64'h2000, 2, 0);
        step("p3000", 0, 0, 1, 0, 64'h3000, 1, 64'h3000, 3, 0);
        step("hold",  0, 0, 0, 0, 64'hdead, 1, 64'h3000, 3, 0);
        step("pop1",  0, 0, 0, 1, 0,        1, 64'h2000, 2, 0);
        step("pop2",  0, 0, 0, 1, 0,        1, 64'h1000, 1, 0);
        step("pop3",  0, 0, 0, 1, 0,        0, 0,        0, 0);

        // Overflow at DEPTH = 4
        step("pA0", 0, 0, 1, 0, 64'hA0, 1, 64'hA0, 1, 0);
        step("pA4", 0, 0, 1, 0, 64'hA4, 1, 64'hA4, 2, 0);
        step("pA8", 0, 0, 1, 0, 64'hA8, 1, 64'hA8, 3, 0);
        step("pAC", 0, 0, 1, 0, 64'hAC, 1, 64'hAC, 4, 0);
        step("pB0", 0, 0, 1, 0, 64'hB0, 1, 64'hB0, 4, 1);
        step("ovf_clr", 0, 0, 0, 0, 0,  1, 64'hB0, 4, 0);
        step("opop1", 0, 0, 0, 1, 0,    1, 64'hAC, 3, 0);
        step("opop2", 0, 0, 0, 1, 0,    1, 64'hA8, 2, 0);
        step("opop3", 0, 0, 0, 1, 0,    1, 64'hA4, 1, 0);
        step("opop4", 0, 0, 0, 1, 0,    0, 0,      0, 0);

        // Underflow from reset
        step("u_rst",  1, 0, 0, 0, 0,     0, 0,     0, 0);
        step("u_pop1", 0, 0, 0, 1, 0,     0, 0,     0, 0);
        step("u_pop2", 0, 0, 0, 1, 0,     0, 0,     0, 0);
        step("u_p40",  0, 0, 1, 0, 64'h40, 1, 64'h40, 1, 0);

        // Simultaneous push and pop
        step("s_rst",  1, 0, 0, 0, 0,       0, 0,       0, 0);
        step("s_p100", 0, 0, 1, 0, 64'h100, 1, 64'h100, 1, 0);
        step("s_p200", 0, 0, 1, 0, 64'h200, 1, 64'h200, 2, 0);
        step("s_pp300", 0, 0, 1, 1, 64'h300, 1, 64'h300, 2, 0);
        step("s_pop",  0, 0, 0, 1, 0,       1, 64'h100, 1, 0);

        // Push and pop together on an empty stack acts as a push
        step("e_pop",  0, 0, 0, 1, 0,       0, 0,       0, 0);
        step("e_pp77", 0, 0, 1, 1, 64'h77,  1, 64'h77,  1, 0);

        // Flush beats push
        step("f_p500", 0, 0, 1, 0, 64'h500, 1, 64'h500, 2, 0);
        step("f_flush", 0, 1, 1, 0, 64'h600, 0, 0,      0, 0);
        step("f_idle", 0, 0, 0, 0, 0,       0, 0,       0, 0);

        // Flush on a push into a full stack: no overflow pulse
        step("ff_p1", 0, 0, 1, 0, 64'h11, 1, 64'h11, 1, 0);
        step("ff_p2", 0, 0, 1, 0, 64'h12, 1, 64'h12, 2, 0);
        step("ff_p3", 0, 0, 1, 0, 64'h13, 1, 64'h13, 3, 0);
        step("ff_p4", 0, 0, 1, 0, 64'h14, 1, 64'h14, 4, 0);
        step("ff_fl", 0, 1, 1, 0, 64'h15, 0, 0,      0, 0);

        // Reset mid-operation with a pop in the same cycle
        step("r_p1", 0, 0, 1, 0, 64'h1, 1, 64'h1, 1, 0);
        step("r_p2", 0, 0, 1, 0, 64'h2, 1, 64'h2, 2, 0);
        step("r_p3", 0, 0, 1, 0, 64'h3, 1, 64'h3, 3, 0);
        step("r_rstpop", 1, 0, 0, 1, 0, 0, 0,     0, 0);
        step("r_p8", 0, 0, 1, 0, 64'h8, 1, 64'h8, 1, 0);

        chk("scoreboard", "drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
